arb_grant_dispatch: RTL and testbench
=====================================

// Module: arb_grant_dispatch
// PURPOSE
// - Downstream stage of the 4-requester arbiters (round-robin or priority). Consumes the 2-bit
//   arb_gnt index and the four request lines.
// - Opens a burst for the granted requester and streams its payload beats onto one shared output
//   channel with valid/ready flow control. Pulses a per-requester ack for each beat it takes.
// - Holds ownership until the burst completes, so the arbiter's per-cycle grant changes do not
//   split a burst.
// PARAMETERS
// - DATA_W  32  payload width per beat
// - LEN_W    4  burst length field width; beats = len+1 (1..16 at default)
// PORTS
// - arb_clk              in   1        single clock, rising edge
// - arb_rst_n            in   1        asynchronous assert, active-low reset
// - arb_req0..arb_req3   in   1 each   request lines (same signals the arbiter sees)
// - arb_gnt              in   2        registered grant index from the arbiter
// - req_data0..3         in   DATA_W   current beat payload of each requester
// - req_len0..3          in   LEN_W    burst length-1 of each requester, sampled at burst start
// - req_ack0..3          out  1 each   comb pulse: this cycle's req_dataN is taken; requester advances next edge
// - out_valid            out  1        output beat valid
// - out_ready            in   1        sink accepts beat when out_valid & out_ready
// - out_data             out  DATA_W   beat payload (registered)
// - out_id               out  2        owning requester index
// - out_last             out  1        final beat of burst
// - disp_busy            out  1        burst in progress (state != IDLE)
// - err_trunc            out  1        1-cycle pulse: burst truncated because owner dropped request
// BEHAVIOUR
// - Reset (async, any time incl. mid-burst): state=IDLE, out_valid=0, out_data=0, out_id=0,
//   out_last=0, beats_left=0, err_trunc=0.
//   - req_ackN=0 while in reset.
//   - Any burst in flight is discarded; no beat is emitted after reset release without a new start.
// - FSM: IDLE, BUSY.
// - IDLE:
//   - Start when arb_req[arb_gnt]=1; a grant to a non-requesting index is ignored.
//   - On start, load regs from requester g=arb_gnt: out_valid<=1, out_id<=g, out_data<=req_data[g],
//     beats_left<=req_len[g], out_last<=(req_len[g]==0).
//   - Assert req_ack[g]=1 in the start cycle. Next state BUSY.
// - BUSY: out_valid=1. out_data/out_id/out_last are held stable while out_ready=0.
//   - Accept with out_last=1: out_valid<=0, out_last<=0, next IDLE. No ack this cycle.
//   - Accept with out_last=0 and arb_req[out_id]=1: load next beat.
//     - out_data<=req_data[out_id], beats_left<=beats_left-1, out_last<=(beats_left==1).
//     - req_ack[out_id]=1 this cycle.
//   - Accept with out_last=0 and arb_req[out_id]=0: truncate.
//     - out_valid<=0, err_trunc<=1 for one cycle, next IDLE. No ack.
//   - A request drop while out_ready=0 is not acted on until the pending beat is accepted.
// - req_ackN = load_en & (load_id==N); combinational, at most one ack high per cycle.
// - Latency: req_data is on out_data 1 cycle after its ack. Start is 1 cycle after a grant is seen
//   in IDLE.
// - Throughput: one beat per cycle within a burst. Exactly one idle cycle between bursts (IDLE
//   re-samples arb_gnt).
// - Grant changes while BUSY are ignored. req_len is not re-sampled mid-burst. beats_left never
//   wraps, because the last beat exits BUSY.
// - Payload/len muxing by index: use case on the id; no out-of-range index exists at 2 bits.
// STRUCTURE
// - Shared package arb_pkg:
//   - localparam NUM_REQ=4
//   - typedef logic [1:0] arb_id_t
//   - typedef enum logic {DISP_IDLE, DISP_BUSY} disp_state_t
//   - Also used by the arbiters' grant ports.
// - One sub-module arb_payload_mux: 4:1 mux of {req_data, req_len} by arb_id_t, purely
//   combinational. Instantiated twice: start select by arb_gnt, beat select by out_id.
// - Top holds the FSM, output registers, beats_left counter and ack decode.
// TESTING
// - Single beat: req1=1, gnt=1, len1=0, data1=0xA5, ready=1
//   -> ack1 at start cycle; next cycle valid=1, id=1, data=0xA5, last=1; then valid=0, IDLE.
// - Burst with backpressure: req2=1, len2=3, data2 steps 0x10..0x13 per ack, ready toggles 1/0
//   -> 4 beats 0x10..0x13 in order; last only on 0x13; data held while ready=0; exactly 4 ack2.
// - Grant change mid-burst: req0,req3 both high, gnt=0, len0=2; gnt flips to 3 every cycle
//   -> all 3 beats id=0; req3 burst starts only after 1 idle cycle.
// - Truncation: req3 burst len=5; drop req3 after 2nd beat loaded, ready=1
//   -> 2 beats out, last never set, err_trunc pulses once, disp_busy falls.
// - Reset mid-burst: assert arb_rst_n=0 during a len=7 burst at beat 3
//   -> outputs 0 immediately (async); after release, no beats until a new grant+req.
// - Grant to idle requester: gnt=2, req2=0, others 0 -> no start, no ack, out_valid stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester arbiter family and its grant dispatcher.
// NUM_REQ is the requester count. arb_id_t is the grant or owner index.
// disp_state_t holds the dispatcher FSM states.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] arb_id_t;

    typedef enum logic {
        DISP_IDLE,
        DISP_BUSY
    } disp_state_t;

endpackage

// File: rtl/arb_grant_dispatch_if.sv
// Shared output beat channel of the grant dispatcher.
// Handshake: a beat transfers on a rising clock edge when out_valid and out_ready are both high.
// Once out_valid is raised, the source holds out_data, out_id and out_last stable
// until that transfer happens. out_ready may change freely.
// Signals:
//   out_valid  source -> sink  beat valid
//   out_ready  sink -> source  sink accepts the beat
//   out_data   source -> sink  beat payload
//   out_id     source -> sink  owning requester index
//   out_last   source -> sink  final beat of the burst
// Modports: master = dispatcher side, slave = consumer side.
interface arb_grant_dispatch_if
    import arb_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    arb_id_t           out_id;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_id,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_id,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/arb_payload_mux.sv
// Combinational 4:1 selection of one requester's {payload, burst length} by index.
// Ports:
//   sel          requester index
//   data0..3     per-requester payload
//   len0..3      per-requester burst length-1
//   data, len    selected payload and length
module arb_payload_mux
    import arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  arb_id_t           sel,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [LEN_W-1:0]  len2,
    input  logic [LEN_W-1:0]  len3,
    output logic [DATA_W-1:0] data,
    output logic [LEN_W-1:0]  len
);

    always_comb begin
        data = '0;
        len  = '0;
        // A 2-bit index has no out-of-range value, so these four arms cover every case.
        case (sel)
            2'd0: begin data = data0; len = len0; end
            2'd1: begin data = data1; len = len1; end
            2'd2: begin data = data2; len = len2; end
            2'd3: begin data = data3; len = len3; end
        endcase
    end

endmodule

// File: rtl/arb_grant_dispatch.sv
// Grant dispatcher that sits after a 4-requester arbiter.
// In IDLE it opens a burst for the granted requester, provided that requester is
// actually requesting. It then streams the requester's beats onto one shared output
// channel and keeps ownership until the burst ends, so grant changes mid-burst are ignored.
// Ports:
//   arb_clk, arb_rst_n   clock, asynchronous active-low reset
//   arb_req0..3          request lines
//   arb_gnt              registered grant index from the arbiter
//   req_data0..3         current beat payload of each requester
//   req_len0..3          burst length-1, sampled only at burst start
//   req_ack0..3          combinational: this cycle's payload is taken
//   out_ch               output beat channel (master side)
//   disp_busy            burst in progress
//   err_trunc            1-cycle pulse: owner dropped its request mid-burst
//   dbg_state            current FSM state
module arb_grant_dispatch
    import arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                 arb_clk,
    input  logic                 arb_rst_n,
    input  logic                 arb_req0,
    input  logic                 arb_req1,
    input  logic                 arb_req2,
    input  logic                 arb_req3,
    input  arb_id_t              arb_gnt,
    input  logic [DATA_W-1:0]    req_data0,
    input  logic [DATA_W-1:0]    req_data1,
    input  logic [DATA_W-1:0]    req_data2,
    input  logic [DATA_W-1:0]    req_data3,
    input  logic [LEN_W-1:0]     req_len0,
    input  logic [LEN_W-1:0]     req_len1,
    input  logic [LEN_W-1:0]     req_len2,
    input  logic [LEN_W-1:0]     req_len3,
    output logic                 req_ack0,
    output logic                 req_ack1,
    output logic                 req_ack2,
    output logic                 req_ack3,
    arb_grant_dispatch_if.master out_ch,
    output logic                 disp_busy,
    output logic                 err_trunc,
    output disp_state_t          dbg_state
);

    disp_state_t       state, state_next;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    arb_id_t           out_id_q;
    logic              out_last_q;
    logic [LEN_W-1:0]  beats_left_q;
    logic              err_trunc_q;

    logic [NUM_REQ-1:0] req_vec;
    logic              start, beat_load, finish, trunc;
    logic              load_en;
    arb_id_t           load_id;

    logic [DATA_W-1:0] start_data, beat_data;
    logic [LEN_W-1:0]  start_len, beat_len_unused;

    assign req_vec = {arb_req3, arb_req2, arb_req1, arb_req0};

    // Start path: select by the incoming grant.
    arb_payload_mux #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_start_mux (
        .sel   (arb_gnt),
        .data0 (req_data0), .data1 (req_data1), .data2 (req_data2), .data3 (req_data3),
        .len0  (req_len0),  .len1  (req_len1),  .len2  (req_len2),  .len3  (req_len3),
        .data  (start_data),
        .len   (start_len)
    );

    // Beat path: select by the current owner. Length is not re-sampled mid-burst.
    arb_payload_mux #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_beat_mux (
        .sel   (out_id_q),
        .data0 (req_data0), .data1 (req_data1), .data2 (req_data2), .data3 (req_data3),
        .len0  (req_len0),  .len1  (req_len1),  .len2  (req_len2),  .len3  (req_len3),
        .data  (beat_data),
        .len   (beat_len_unused)
    );

    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state <= DISP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        beat_load  = 1'b0;
        finish     = 1'b0;
        trunc      = 1'b0;
        case (state)
            DISP_IDLE: begin
                // A grant to an index that is not requesting does not open a burst.
                if (req_vec[arb_gnt]) begin
                    start      = 1'b1;
                    state_next = DISP_BUSY;
                end
            end
            DISP_BUSY: begin
                // out_valid is always high in BUSY, so out_ready alone means a transfer.
                // A request drop is only acted on once the pending beat has gone.
                if (out_ch.out_ready) begin
                    if (out_last_q) begin
                        finish     = 1'b1;
                        state_next = DISP_IDLE;
                    end else if (req_vec[out_id_q]) begin
                        beat_load  = 1'b1;
                    end else begin
                        trunc      = 1'b1;
                        state_next = DISP_IDLE;
                    end
                end
            end
            default: state_next = DISP_IDLE;
        endcase
    end

    // Gating with the reset keeps acks low while reset is held.
    // Without it, a grant seen in IDLE during reset could still raise an ack.
    assign load_en = (start | beat_load) & arb_rst_n;
    assign load_id = start ? arb_gnt : out_id_q;

    assign req_ack0 = load_en & (load_id == 2'd0);
    assign req_ack1 = load_en & (load_id == 2'd1);
    assign req_ack2 = load_en & (load_id == 2'd2);
    assign req_ack3 = load_en & (load_id == 2'd3);

    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            out_last_q   <= 1'b0;
            beats_left_q <= '0;
            err_trunc_q  <= 1'b0;
        end else begin
            err_trunc_q <= trunc;
            if (start) begin
                out_valid_q  <= 1'b1;
                out_id_q     <= arb_gnt;
                out_data_q   <= start_data;
                beats_left_q <= start_len;
                out_last_q   <= (start_len == '0);
            end else if (beat_load) begin
                out_data_q   <= beat_data;
                beats_left_q <= beats_left_q - LEN_W'(1);
                out_last_q   <= (beats_left_q == LEN_W'(1));
            end else if (finish) begin
                out_valid_q  <= 1'b0;
                out_last_q   <= 1'b0;
            end else if (trunc) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign out_ch.out_valid = out_valid_q;
    assign out_ch.out_data  = out_data_q;
    assign out_ch.out_id    = out_id_q;
    assign out_ch.out_last  = out_last_q;
    assign disp_busy        = (state != DISP_IDLE);
    assign err_trunc        = err_trunc_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_arb_grant_dispatch.sv
module tb_arb_grant_dispatch;
    import arb_pkg::*;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    logic [3:0]        req;
    arb_id_t           gnt;
    logic [DATA_W-1:0] rdata [4];
    logic [LEN_W-1:0]  rlen  [4];
    logic              ack0, ack1, ack2, ack3;
    logic [3:0]        acks;
    logic              disp_busy, err_trunc;
    disp_state_t       dbg_state;

    assign acks = {ack3, ack2, ack1, ack0};

    arb_grant_dispatch_if #(.DATA_W(DATA_W)) out_ch ();

    arb_grant_dispatch #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .arb_clk   (clk),
        .arb_rst_n (rst_n),
        .arb_req0  (req[0]),
        .arb_req1  (req[1]),
        .arb_req2  (req[2]),
        .arb_req3  (req[3]),
        .arb_gnt   (gnt),
        .req_data0 (rdata[0]),
        .req_data1 (rdata[1]),
        .req_data2 (rdata[2]),
        .req_data3 (rdata[3]),
        .req_len0  (rlen[0]),
        .req_len1  (rlen[1]),
        .req_len2  (rlen[2]),
        .req_len3  (rlen[3]),
        .req_ack0  (ack0),
        .req_ack1  (ack1),
        .req_ack2  (ack2),
        .req_ack3  (ack3),
        .out_ch    (out_ch.master),
        .disp_busy (disp_busy),
        .err_trunc (err_trunc),
        .dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int vectors    = 0;
    int miscompares = 0;
    int ack_cnt [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check acks after letting combinational paths settle.
    task automatic chk_acks(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, 32'(acks), 32'(exp));
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] id, input logic [31:0] data,
                            input logic last);
        chk({tag, "_valid"}, 32'(out_ch.out_valid), 32'd1);
        chk({tag, "_id"},    32'(out_ch.out_id),    32'(id));
        chk({tag, "_data"},  out_ch.out_data,       data);
        chk({tag, "_last"},  32'(out_ch.out_last),  32'(last));
    endtask

    // Requester model: a requester steps to its next payload on the edge after its ack.
    // Returns 1 time unit after the rising edge.
    task automatic cyc();
        logic [3:0] a;
        @(negedge clk);
        a = acks;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
                rdata[i] = rdata[i] + 32'd1;
                ack_cnt[i]++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        gnt   = 2'd0;
        out_ch.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdata[i]   = '0;
            rlen[i]    = '0;
            ack_cnt[i] = 0;
        end

        // Reset state
        #12;
        chk("rst_valid", 32'(out_ch.out_valid), 32'd0);
        chk("rst_data",  out_ch.out_data,       32'd0);
        chk("rst_id",    32'(out_ch.out_id),    32'd0);
        chk("rst_last",  32'(out_ch.out_last),  32'd0);
        chk("rst_busy",  32'(disp_busy),        32'd0);
        chk("rst_err",   32'(err_trunc),        32'd0);
        chk("rst_state", 32'(dbg_state),        32'(DISP_IDLE));
        chk("rst_acks",  32'(acks),             32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single beat
        req[1] = 1'b1; gnt = 2'd1; rlen[1] = 4'd0; rdata[1] = 32'hA5;
        out_ch.out_ready = 1'b1;
        chk_acks("single_start_ack", 4'b0010);
        cyc();
        chk_beat("single_beat", 2'd1, 32'hA5, 1'b1);
        chk("single_busy", 32'(disp_busy), 32'd1);
        req[1] = 1'b0;
        chk_acks("single_last_noack", 4'b0000);
        cyc();
        chk("single_end_valid", 32'(out_ch.out_valid), 32'd0);
        chk("single_end_busy",  32'(disp_busy),        32'd0);
        chk("single_end_last",  32'(out_ch.out_last),  32'd0);

        // Burst of 4 with ready toggling
        gnt = 2'd2; req[2] = 1'b1; rlen[2] = 4'd3; rdata[2] = 32'h10; ack_cnt[2] = 0;
        chk_acks("burst_start_ack", 4'b0100);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk_beat("burst_beat", 2'd2, 32'h10 + 32'(k), (k == 3));
            out_ch.out_ready = 1'b0;
            if (k == 3) req[2] = 1'b0;
            chk_acks("burst_stall_noack", 4'b0000);
            cyc();
            chk("burst_hold_data", out_ch.out_data, 32'h10 + 32'(k));
            chk("burst_hold_last", 32'(out_ch.out_last), 32'((k == 3)));
            out_ch.out_ready = 1'b1;
            chk_acks("burst_accept_ack", (k == 3) ? 4'b0000 : 4'b0100);
            cyc();
        end
        chk("burst_end_valid", 32'(out_ch.out_valid), 32'd0);
        chk("burst_ack_count", 32'(ack_cnt[2]),       32'd4);

        // Grant flips every cycle while busy
        req = 4'b1001; gnt = 2'd0; rlen[0] = 4'd2; rlen[3] = 4'd0;
        rdata[0] = 32'h20; rdata[3] = 32'h30;
        chk_acks("flip_start_ack", 4'b0001);
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk_beat("flip_beat", 2'd0, 32'h20 + 32'(k), (k == 2));
            gnt = (k % 2 == 0) ? 2'd3 : 2'd0;
            if (k == 2) req[0] = 1'b0;
            chk_acks("flip_ack", (k == 2) ? 4'b0000 : 4'b0001);
            cyc();
        end
        chk("flip_idle_valid", 32'(out_ch.out_valid), 32'd0);
        chk("flip_idle_busy",  32'(disp_busy),        32'd0);
        chk_acks("flip_req3_ack", 4'b1000);
        cyc();
        chk_beat("flip_req3_beat", 2'd3, 32'h30, 1'b1);
        req[3] = 1'b0;
        cyc();
        chk("flip_end_valid", 32'(out_ch.out_valid), 32'd0);

        // Truncation
        gnt = 2'd3; req[3] = 1'b1; rlen[3] = 4'd5; rdata[3] = 32'h40;
        chk_acks("trunc_start_ack", 4'b1000);
        cyc();
        chk_beat("trunc_beat0", 2'd3, 32'h40, 1'b0);
        chk_acks("trunc_load_ack", 4'b1000);
        cyc();
        chk_beat("trunc_beat1", 2'd3, 32'h41, 1'b0);
        req[3] = 1'b0;
        chk_acks("trunc_noack", 4'b0000);
        cyc();
        chk("trunc_valid", 32'(out_ch.out_valid), 32'd0);
        chk("trunc_err",   32'(err_trunc),        32'd1);
        chk("trunc_busy",  32'(disp_busy),        32'd0);
        chk("trunc_last",  32'(out_ch.out_last),  32'd0);
        cyc();
        chk("trunc_err_clear", 32'(err_trunc),        32'd0);
        chk("trunc_stay_idle", 32'(out_ch.out_valid), 32'd0);

        // Reset in the middle of a burst
        gnt = 2'd1; req[1] = 1'b1; rlen[1] = 4'd7; rdata[1] = 32'h50;
        cyc();
        cyc();
        cyc();
        chk_beat("rstmid_beat2", 2'd1, 32'h52, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(out_ch.out_valid), 32'd0);
        chk("rstmid_data",  out_ch.out_data,       32'd0);
        chk("rstmid_id",    32'(out_ch.out_id),    32'd0);
        chk("rstmid_last",  32'(out_ch.out_last),  32'd0);
        chk("rstmid_busy",  32'(disp_busy),        32'd0);
        chk("rstmid_acks",  32'(acks),             32'd0);
        req[1] = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("rstmid_after_valid", 32'(out_ch.out_valid), 32'd0);
        chk("rstmid_after_busy",  32'(disp_busy),        32'd0);
        req[1] = 1'b1; rlen[1] = 4'd0; rdata[1] = 32'h60;
        chk_acks("rstmid_new_ack", 4'b0010);
        cyc();
        chk_beat("rstmid_new_beat", 2'd1, 32'h60, 1'b1);
        req[1] = 1'b0;
        cyc();

        // Grant to an idle requester
        gnt = 2'd2; req = 4'b0000;
        chk_acks("idle_gnt_noack", 4'b0000);
        cyc();
        cyc();
        cyc();
        chk("idle_gnt_valid", 32'(out_ch.out_valid), 32'd0);
        chk("idle_gnt_busy",  32'(disp_busy),        32'd0);
        chk("idle_gnt_state", 32'(dbg_state),        32'(DISP_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
